seg_scan_driver: RTL and testbench
==================================

Name: seg_scan_driver

Overview:
- Time-multiplexed 3-digit seven-segment driver. It sits directly downstream of the binary-to-BCD converter in the seven_seg_display design and consumes that converter's 12-bit packed BCD word.
- Captures BCD values on a load strobe and commits them only at frame boundaries, so the display never tears.
- Scans the digits with dead-time, leading-zero blanking and invalid-digit indication.

Parameters:
- REFRESH_DIV, 50000, clock cycles per digit slot; legal range >= 2.
- DEAD_CYC, 2, cycles at the start of each slot with all anodes inactive; legal range 0 .. REFRESH_DIV-1.
- SEG_ACTIVE_LOW, 1, 1 = seg/dp pins are inverted at the output.
- AN_ACTIVE_LOW, 1, 1 = an pins are inverted at the output.

Ports:
- clk  in  1  system clock; single clock domain.
- rst_n  in  1  asynchronous active-low reset.
- bcd_in  in  12  {hundreds, tens, units} BCD nibbles.
- load  in  1  single-cycle strobe; captures bcd_in.
- dp_in  in  3  decimal point per digit; bit0 = units. Live input, not captured.
- blank_lz  in  1  1 = enable leading-zero blanking.
- pending  out  1  a captured value is waiting for the frame boundary.
- seg  out  7  {g,f,e,d,c,b,a} at pin polarity.
- dp  out  1  decimal point at pin polarity.
- an  out  3  digit enables at pin polarity; bit0 = units.

Behaviour:
- Reset is asynchronous and active-low; clk is the only clock.
- Reset values:
  - prescaler = 0, digit index = 0, disp register = 0, pend register = 0, pending = 0.
  - seg, dp and an are all driven to their inactive pin level.
- Prescaler:
  - Counts 0 .. REFRESH_DIV-1 and wraps.
  - tick = (prescaler == REFRESH_DIV-1).
  - On tick, the index advances 0 -> 1 -> 2 -> 0.
  - frame_end = tick && (index == 2).
- Load handshake:
  - load=1 sets pend <= bcd_in and pending <= 1. A later load before commit overwrites pend; last value wins.
  - On frame_end with pending=1: disp <= pend, pending <= 0.
  - If load and frame_end occur in the same cycle: disp <= bcd_in directly, pending <= 0.
  - load while pending=0 and no frame_end: value is held until the next frame_end. Worst-case commit latency is 3*REFRESH_DIV cycles.
- Digit selection: index 0 = disp[3:0], index 1 = disp[7:4], index 2 = disp[11:8].
- Blanking (only when blank_lz=1):
  - Hundreds is blank if its nibble == 0.
  - Tens is blank if hundreds == 0 and tens == 0.
  - Units is never blanked.
  - Invalid nibbles (>9) are never blanked.
- Decode, logical active-high form:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
  - Invalid nibble A-F = 40 (dash).
  - Blanked digit = 00; dp is still shown from dp_in.
- Outputs:
  - seg, dp and an are registered; they reflect the index and disp state of the previous cycle (1-cycle latency).
  - During dead time (prescaler < DEAD_CYC), an is all inactive while seg/dp already show the new digit.
  - Otherwise exactly one an bit is active: the one matching the index.
  - Polarity inversion from the SEG_ACTIVE_LOW / AN_ACTIVE_LOW parameters is applied at the output register.
- Reset mid-scan: all state returns to reset values immediately; the pending value is discarded.

Decomposition:
- Shared package seg_pkg holds:
  - the 7-bit segment constants SEG_0..SEG_9, SEG_DASH, SEG_BLANK;
  - the digit count constant NUM_DIGITS = 3;
  - the BCD nibble width constant.
- One combinational sub-module, bcd_to_seg: 4-bit nibble plus blank flag -> 7-bit logical segments. It is reused by later display blocks.
- Prescaler, index, load/commit logic and output registers stay in seg_scan_driver.

Test Plan (REFRESH_DIV=4, DEAD_CYC=1, both polarities active-low unless stated):
- Reset: hold rst_n=0 -> seg=7F, dp=1, an=7, pending=0. Release -> first frame shows digit 0 = 0 (seg=40 at pin), hundreds and tens blank when blank_lz=1.
- Load 12'h255, then wait for frame_end:
  - an sequence per slot: 7 for 1 cycle, then 6 for 3 cycles; then 7, then 5; then 7, then 3.
  - seg pins: 12 ("5"), 24 ("2"), 24 ("2").
- Leading-zero blanking: load 12'h007 with blank_lz=1 -> units 07, tens and hundreds 00. Same load with blank_lz=0 -> tens and hundreds show 3F.
- Mid-frame load:
  - Load 12'h123 during slot 1 -> pending=1 and the display keeps the old value until frame_end, then shows 1/2/3 and pending=0.
  - Second load 12'h456 before commit -> 456 is shown, not 123.
- Load coincident with frame_end, value 12'h0A9 -> committed that cycle with pending staying 0. Units shows 6F, tens shows 40 (dash), hundreds blank.
- Reset asserted mid-slot with pending=1 -> outputs go inactive asynchronously. After release, pending=0 and disp=0.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment display blocks.
package seg_pkg;

  localparam int unsigned NUM_DIGITS = 3;
  localparam int unsigned BCD_W      = 4;

  // Logical active-high segment patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_DASH  = 7'h40;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  // Scan position, also the digit weight
  typedef enum logic [1:0] {
    DIG_UNITS    = 2'd0,
    DIG_TENS     = 2'd1,
    DIG_HUNDREDS = 2'd2
  } digit_e;

endpackage

// File: rtl/bcd_to_seg.sv
// One BCD nibble to logical seven-segment pattern; invalid nibbles show a dash.
module bcd_to_seg
  import seg_pkg::*;
(
  input  logic [BCD_W-1:0] nibble,
  input  logic             blank,
  output logic [6:0]       seg
);

  // Pattern lookup, blank overrides the digit
  always_comb begin
    seg = SEG_DASH;
    if (blank) begin
      seg = SEG_BLANK;
    end else begin
      case (nibble)
        4'd0:    seg = SEG_0;
        4'd1:    seg = SEG_1;
        4'd2:    seg = SEG_2;
        4'd3:    seg = SEG_3;
        4'd4:    seg = SEG_4;
        4'd5:    seg = SEG_5;
        4'd6:    seg = SEG_6;
        4'd7:    seg = SEG_7;
        4'd8:    seg = SEG_8;
        4'd9:    seg = SEG_9;
        default: seg = SEG_DASH;
      endcase
    end
  end

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed 3-digit seven-segment scanner with frame-aligned commit,
// dead-time, leading-zero blanking and registered pin-polarity outputs.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int unsigned REFRESH_DIV    = 50000,
  parameter int unsigned DEAD_CYC       = 2,
  parameter bit          SEG_ACTIVE_LOW = 1'b1,
  parameter bit          AN_ACTIVE_LOW  = 1'b1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_DIGITS*BCD_W-1:0] bcd_in,
  input  logic                        load,
  input  logic [NUM_DIGITS-1:0]       dp_in,
  input  logic                        blank_lz,
  output logic                        pending,
  output logic [6:0]                  seg,
  output logic                        dp,
  output logic [NUM_DIGITS-1:0]       an
);

  localparam int unsigned PW = $clog2(REFRESH_DIV);
  localparam int unsigned DW = NUM_DIGITS * BCD_W;
  localparam logic [PW-1:0] PS_MAX = PW'(REFRESH_DIV - 1);
  localparam logic [PW-1:0] PS_DEAD = PW'(DEAD_CYC);

  logic [PW-1:0] prescaler, prescaler_nxt;
  digit_e        idx, idx_nxt;
  logic [DW-1:0] disp, disp_nxt;
  logic [DW-1:0] pend, pend_nxt;
  logic          pending_nxt;
  logic          tick, frame_end;

  logic [BCD_W-1:0]      nib, hund, tens;
  logic                  blank;
  logic                  dp_log;
  logic [NUM_DIGITS-1:0] an_sel, an_log;
  logic [6:0]            seg_log;

  assign tick      = (prescaler == PS_MAX);
  assign frame_end = tick && (idx == DIG_HUNDREDS);

  // Scan state and commit registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prescaler <= '0;
      idx       <= DIG_UNITS;
      disp      <= '0;
      pend      <= '0;
      pending   <= 1'b0;
    end else begin
      prescaler <= prescaler_nxt;
      idx       <= idx_nxt;
      disp      <= disp_nxt;
      pend      <= pend_nxt;
      pending   <= pending_nxt;
    end
  end

  // Prescaler wrap, digit advance and load/commit handshake.
  // A load landing on frame_end bypasses pend so it is not delayed a frame.
  always_comb begin
    prescaler_nxt = tick ? '0 : prescaler + 1'b1;
    idx_nxt       = idx;
    disp_nxt      = disp;
    pend_nxt      = pend;
    pending_nxt   = pending;
    if (tick) begin
      case (idx)
        DIG_UNITS: idx_nxt = DIG_TENS;
        DIG_TENS:  idx_nxt = DIG_HUNDREDS;
        default:   idx_nxt = DIG_UNITS;
      endcase
    end
    if (load && frame_end) begin
      disp_nxt    = bcd_in;
      pending_nxt = 1'b0;
    end else if (load) begin
      pend_nxt    = bcd_in;
      pending_nxt = 1'b1;
    end else if (frame_end && pending) begin
      disp_nxt    = pend;
      pending_nxt = 1'b0;
    end
  end

  assign hund = disp[2*BCD_W +: BCD_W];
  assign tens = disp[BCD_W +: BCD_W];

  // Digit, decimal point, anode and blanking selection for the current slot
  always_comb begin
    nib    = disp[0 +: BCD_W];
    dp_log = dp_in[0];
    an_sel = 3'b001;
    blank  = 1'b0;
    case (idx)
      DIG_TENS: begin
        nib    = tens;
        dp_log = dp_in[1];
        an_sel = 3'b010;
        blank  = blank_lz && (hund == '0) && (tens == '0);
      end
      DIG_HUNDREDS: begin
        nib    = hund;
        dp_log = dp_in[2];
        an_sel = 3'b100;
        blank  = blank_lz && (hund == '0);
      end
      default: ;
    endcase
    an_log = (prescaler < PS_DEAD) ? '0 : an_sel;
  end

  bcd_to_seg u_dec (
    .nibble (nib),
    .blank  (blank),
    .seg    (seg_log)
  );

  // Output register; polarity applied here so reset lands on the inactive level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg <= {7{SEG_ACTIVE_LOW}};
      dp  <= SEG_ACTIVE_LOW;
      an  <= {NUM_DIGITS{AN_ACTIVE_LOW}};
    end else begin
      seg <= seg_log ^ {7{SEG_ACTIVE_LOW}};
      dp  <= dp_log ^ SEG_ACTIVE_LOW;
      an  <= an_log ^ {NUM_DIGITS{AN_ACTIVE_LOW}};
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Scoreboard bench for seg_scan_driver with REFRESH_DIV=4, DEAD_CYC=1, active-low pins.
module tb_seg_scan_driver;

  localparam int DIV   = 4;
  localparam int DEAD  = 1;
  localparam int FRAME = 3 * DIV;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [11:0] bcd_in;
  logic        load;
  logic [2:0]  dp_in;
  logic        blank_lz;
  logic        pending;
  logic [6:0]  seg;
  logic        dp;
  logic [2:0]  an;

  seg_scan_driver #(
    .REFRESH_DIV    (DIV),
    .DEAD_CYC       (DEAD),
    .SEG_ACTIVE_LOW (1'b1),
    .AN_ACTIVE_LOW  (1'b1)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bcd_in   (bcd_in),
    .load     (load),
    .dp_in    (dp_in),
    .blank_lz (blank_lz),
    .pending  (pending),
    .seg      (seg),
    .dp       (dp),
    .an       (an)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0] seg;
    logic       dp;
    logic [2:0] an;
    logic       pend;
  } exp_t;

  exp_t exp_q [$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // Digit glyphs indexed by nibble value; 10..15 are the dash
  logic [6:0] glyph [0:15] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                              7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};

  // Reference model: k is the index of the next clock edge since reset release
  int          k = 0;
  logic [11:0] m_shown = '0;
  logic [11:0] m_latest = '0;
  logic        m_waiting = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
  endtask

  // Model advances one clock and predicts the outputs registered on this edge
  always @(posedge clk) begin
    if (!rst_n) begin
      k = 0;
      m_shown = '0;
      m_latest = '0;
      m_waiting = 1'b0;
    end else begin
      exp_t e;
      int   pos;
      int   phase;
      logic [3:0] h, t, d;
      logic hide;
      phase = k % DIV;
      pos   = (k / DIV) % 3;
      h = m_shown[11:8];
      t = m_shown[7:4];
      d = m_shown[pos*4 +: 4];
      hide = blank_lz && ((pos == 2 && h == 0) || (pos == 1 && h == 0 && t == 0));
      e.seg = ~(hide ? 7'h00 : glyph[d]);
      e.dp  = ~dp_in[pos];
      e.an  = (phase < DEAD) ? 3'b111 : ~(3'b001 << pos);
      // The most recent load becomes visible at the end of the current frame
      if (k % FRAME == FRAME - 1) begin
        if (load) m_shown = bcd_in;
        else if (m_waiting) m_shown = m_latest;
        m_waiting = 1'b0;
      end else if (load) begin
        m_latest = bcd_in;
        m_waiting = 1'b1;
      end
      e.pend = m_waiting;
      exp_q.push_back(e);
      k++;
    end
  end

  // Monitor: compare registered outputs half a cycle after each edge
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      check("rst_seg", 32'(seg), 32'h7F);
      check("rst_dp", 32'(dp), 32'h1);
      check("rst_an", 32'(an), 32'h7);
      check("rst_pending", 32'(pending), 32'h0);
    end else if (exp_q.size() == 0) begin
      check("queue_empty", 32'(exp_q.size()), 32'h1);
    end else begin
      exp_t e;
      e = exp_q.pop_front();
      check("seg", 32'(seg), 32'(e.seg));
      check("dp", 32'(dp), 32'(e.dp));
      check("an", 32'(an), 32'(e.an));
      check("pending", 32'(pending), 32'(e.pend));
    end
  end

  task automatic cyc();
    @(negedge clk);
    #1;
    dp_in = 3'($urandom);
  endtask

  task automatic run(input int n);
    repeat (n) cyc();
  endtask

  task automatic load_now(input logic [11:0] v);
    bcd_in = v;
    load = 1'b1;
    cyc();
    load = 1'b0;
    bcd_in = 12'($urandom);
  endtask

  task automatic do_load(input logic [11:0] v);
    cyc();
    load_now(v);
  endtask

  // Wait (bounded) until the next edge sits at the given position in the frame
  task automatic align(input int target);
    for (int i = 0; i < FRAME; i++) begin
      if (k % FRAME == target) break;
      cyc();
    end
    check("align", 32'(k % FRAME), 32'(target));
  endtask

  initial begin
    rst_n = 1'b0;
    load = 1'b0;
    bcd_in = '0;
    dp_in = '0;
    blank_lz = 1'b1;
    run(3);
    rst_n = 1'b1;
    run(FRAME + 2);

    do_load(12'h255);
    run(3 * FRAME);

    do_load(12'h007);
    run(2 * FRAME);
    blank_lz = 1'b0;
    run(FRAME + 1);
    blank_lz = 1'b1;

    align(DIV + 1);
    load_now(12'h123);
    run(2);
    load_now(12'h456);
    run(2 * FRAME);

    align(FRAME - 1);
    load_now(12'h0A9);
    run(2 * FRAME);

    do_load(12'h987);
    run(1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("async_seg", 32'(seg), 32'h7F);
    check("async_dp", 32'(dp), 32'h1);
    check("async_an", 32'(an), 32'h7);
    check("async_pending", 32'(pending), 32'h0);
    run(2);
    rst_n = 1'b1;
    run(FRAME + 2);

    for (int i = 0; i < 25; i++) begin
      blank_lz = 1'($urandom);
      run(int'($urandom_range(0, 15)));
      if ($urandom_range(0, 3) == 0) begin
        bcd_in = {4'($urandom_range(0, 1)), 4'($urandom_range(0, 1)), 4'($urandom)};
        load_now(bcd_in);
      end else begin
        do_load(12'($urandom));
      end
    end
    run(3 * FRAME);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
